dec_onehot2bin: RTL
===================

// Module: dec_onehot2bin
// PURPOSE
// - Decodes a one-hot vector back to its binary index; the receive-side counterpart of the binary-to-one-hot encoder.
// - Registered, valid/ready streaming stage with a 2-entry skid buffer, so in_ready is a flop output and never a combinational path.
// - Flags any input that is not exactly one-hot (zero-hot or multi-hot) and emits the reserved code in its place.
// PARAMETERS
// - IN_W   15                   one-hot input width; must satisfy IN_W <= 2**OUT_W - 1
// - OUT_W  $clog2(IN_W+1) (4)   binary output width; all-ones (4'hF) is the reserved error code
// PORTS
// - clk        in   1      clock; all state updates on the rising edge
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      input beat valid
// - in_ready   out  1      stage can accept a beat; registered
// - in         in   IN_W   one-hot vector
// - out_valid  out  1      output beat valid
// - out_ready  in   1      downstream accepts the beat
// - out        out  OUT_W  binary index of the set bit; all-ones on error
// - out_err    out  1      beat's input was zero-hot or multi-hot
// BEHAVIOUR
// - Reset (async assert, sync release): out_valid=0, out=0, out_err=0, both skid entries empty, in_ready=1 from the first edge after release.
// - Transfer rules:
//   - An input beat is accepted when in_valid && in_ready.
//   - An output beat completes when out_valid && out_ready.
// - Latency: exactly 1 cycle from acceptance to out_valid when the output register is empty or draining.
// - Decode:
//   - countones(in)==1 -> out = index of the set bit, out_err = 0.
//   - Otherwise -> out = {OUT_W{1'b1}}, out_err = 1.
//   - A multi-hot input never aliases to a valid index.
// - Stall: while out_valid && !out_ready, out and out_err stay stable, and out_valid stays high until the beat completes.
// - Skid:
//   - Entries are the output register plus one skid register.
//   - A beat accepted while the output is stalled goes to the skid register.
//   - in_ready deasserts on the next edge once both entries are full.
//   - On out_ready, the skid entry moves into the output register and in_ready reasserts.
// - Simultaneous accept and complete with one entry full: the output register reloads with the new beat; there is no bubble and no skid use.
// - Ordering: beats leave in strict arrival order; no drop, duplication or reordering under any out_ready pattern.
// - in is sampled only on acceptance; its value while in_valid=0 is ignored, X included.
// - Reset mid-stream: all entries are discarded immediately and out_valid drops asynchronously.
// - Throughput: 1 beat/cycle when out_ready is held high.
// CONFIGURATION
// - Macro DEC_ERR_CNT_EN.
// - Defined:
//   - Adds output err_cnt [15:0], reset 0.
//   - Increments by 1 on each completed output beat with out_err=1.
//   - Saturates at 16'hFFFF and never wraps.
//   - Adds input err_clr [1]: clears err_cnt to 0. If err_clr coincides with a counting completion, the result is 0.
// - Undefined: neither port exists; error reporting is via out_err only.
// STRUCTURE
// - Package dec_pkg:
//   - Localparams IN_W_DEF=15, OUT_W_DEF=4, ERR_CODE=4'hF.
//   - typedef struct packed {logic [OUT_W-1:0] code; logic err;} dec_beat_t.
//   - function onehot2bin returning dec_beat_t (priority-free OR-tree encode plus a popcount==1 check).
// - Sub-module dec_skid_buf: the generic 2-entry valid/ready skid buffer carrying dec_beat_t. The top holds only the decode function and the optional counter.
// TESTING
// - Reset with in_valid=1 held -> out_valid=0, out=0 during reset; in_ready=1 one cycle after release.
// - out_ready=1, stream in=1<<i for i=0..14 on back-to-back cycles -> out=i, out_err=0, each 1 cycle after its accept; no bubbles.
// - Illegal inputs:
//   - in=15'h0 -> out=4'hF, out_err=1.
//   - in=15'h0003 -> out=4'hF, out_err=1.
//   - in=15'h7FFF -> out=4'hF, out_err=1.
// - Backpressure:
//   - Hold out_ready=0 and send 1<<3, 1<<9, 1<<12 -> in_ready=0 after the 2nd accept; out holds 3 stable.
//   - Release out_ready -> outputs 3, 9, 12 in order.
// - Random in_valid/out_ready toggling over 10k beats against a scoreboard -> exact order, no loss or duplicate; out is stable during every stall.
// - Assert rst_n mid-stall with both entries full -> out_valid=0 at once; after release, the first new beat is output with no stale data.
// - With DEC_ERR_CNT_EN:
//   - 3 error beats -> err_cnt=3.
//   - err_clr coinciding with a completing error beat -> err_cnt=0.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and the one-hot decode function for the one-hot to binary stage.
// The beat struct is sized by the package defaults; the top's widths are
// expected to match them.
package dec_pkg;

    localparam int IN_W_DEF  = 15;
    localparam int OUT_W_DEF = 4;
    localparam logic [OUT_W_DEF-1:0] ERR_CODE = 4'hF;

    typedef struct packed {
        logic [OUT_W_DEF-1:0] code;
        logic                 err;
    } dec_beat_t;

    // OR-tree encode (every set bit contributes its index, no priority chain)
    // plus an exactly-one-bit check. Anything that is not one-hot returns the
    // reserved code, so multi-hot inputs can never alias to a legal index.
    function automatic dec_beat_t onehot2bin(input logic [IN_W_DEF-1:0] v);
        dec_beat_t            r;
        logic [OUT_W_DEF-1:0] idx;
        logic                 one_hot;
        idx = '0;
        for (int i = 0; i < IN_W_DEF; i++) begin
            idx = idx | ({OUT_W_DEF{v[i]}} & OUT_W_DEF'(i));
        end
        one_hot = (v != '0) && ((v & (v - IN_W_DEF'(1))) == '0);
        r.code  = one_hot ? idx : ERR_CODE;
        r.err   = ~one_hot;
        return r;
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one skid
// register. in_ready_o is a flop, so no combinational path crosses the stage.
//
// Handshake: a beat moves on the upstream side when in_valid_i && in_ready_o
// at a rising edge, and on the downstream side when out_valid_o && out_ready_i
// at a rising edge; a presented output beat holds valid and data stable until
// it completes.
module dec_skid_buf
    import dec_pkg::*;
#(
    parameter type T = dec_beat_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    T     out_q, out_d;
    T     skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;

    logic accept;
    logic complete;

    assign accept   = in_valid_i && in_ready_q;
    assign complete = out_valid_q && out_ready_i;

    // Next-state: the output register refills from the skid entry first, then
    // from the input; a beat arriving while the output is stalled parks in skid.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (complete || !out_valid_q) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
                if (accept) begin
                    skid_d       = in_data_i;
                    skid_valid_d = 1'b1;
                end
            end else if (accept) begin
                out_d       = in_data_i;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end
        // Ready is withheld for the cycle after both entries become full.
        in_ready_d = ~skid_valid_d;
    end

    // State registers; reset discards both entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;

endmodule

// File: rtl/dec_onehot2bin.sv
// One-hot to binary decoder stage with a registered 2-entry skid buffer.
// Non-one-hot inputs produce the all-ones code with out_err set.
// Optional macro DEC_ERR_CNT_EN adds err_clr / err_cnt: a saturating 16-bit
// count of completed error beats, with clear taking priority over counting.
module dec_onehot2bin
    import dec_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
`ifdef DEC_ERR_CNT_EN
    input  logic             err_clr,
    output logic [15:0]      err_cnt,
`endif
    output logic             out_err
);

    dec_beat_t beat_in;
    dec_beat_t beat_out;

    // Decode happens ahead of the buffer; in is only captured on acceptance.
    assign beat_in = onehot2bin(IN_W_DEF'(in));

    dec_skid_buf #(
        .T (dec_beat_t)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (beat_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (beat_out)
    );

    assign out     = beat_out.code;
    assign out_err = beat_out.err;

`ifdef DEC_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_done;

    assign err_done = out_valid && out_ready && beat_out.err;

    // Counter next-state: clear wins, otherwise count error completions up to saturation.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_done && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
